// File: rtl/not_game_pkg.sv
// -----------------------------------------------------------------------------
// not_game_pkg
// Shared definitions for the NOT-NOT game datapath.
//   - Direction codes. They match the bit index of the key_n pushbutton bus.
//   - The LFSR tap mask and the LFSR step function.
//   - The lowest-pressed-key priority helper.
//   - The default wait-timer length and the default starting lives.
// -----------------------------------------------------------------------------
package not_game_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  // Feedback taps at bit positions 8,6,5,4 (1-based), i.e. bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned WAIT_CYCLES_DEF = 50_000_000;
  localparam int unsigned LIVES_INIT_DEF  = 3;

  // Fibonacci step: shift left and insert the parity of the tapped bits.
  // A non-zero state can never map to zero, so the sequence cannot lock up.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Priority pick among simultaneously pressed keys: the lowest index wins.
  function automatic dir_t lowest_key(input logic [3:0] down);
    dir_t idx;
    idx = DIR_UP;
    if (down[3]) idx = DIR_RIGHT;
    if (down[2]) idx = DIR_LEFT;
    if (down[1]) idx = DIR_DOWN;
    if (down[0]) idx = DIR_UP;
    return idx;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Inter-round wait timer for the NOT-NOT game.
// The count is held at zero while clear_i is high. When clear_i is low the
// count goes up by one per clock and stops at WAIT_CYCLES. expired_o is a
// registered flag. It is high exactly when the count sits at WAIT_CYCLES.
//
// Ports
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   clear_i    in  clear and restart (the FSM's enable_counter)
//   expired_o  out timer has reached WAIT_CYCLES (registered)
// -----------------------------------------------------------------------------
module wait_timer #(
  parameter int unsigned WAIT_CYCLES = 50_000_000,
  parameter int          CNT_W       = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear_i) begin
      cnt_d     = '0;
      expired_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      // The flag tracks the next count, so it rises on the same edge at
      // which the count reaches WAIT_CYCLES.
      expired_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/not_judge_datapath.sv
// -----------------------------------------------------------------------------
// not_judge_datapath
// Datapath and responder for the NOT-NOT game control FSM. Its jobs:
//   - synchronize the pushbuttons;
//   - capture the player's key;
//   - judge the key against the current instruction;
//   - generate pseudo-random instructions;
//   - run the inter-round wait timer;
//   - keep lives and score.
//
// Ports
//   clk                in   clock
//   rst_n              in   asynchronous active-low reset
//   key_n[3:0]         in   raw pushbuttons, active-low: UP, DOWN, LEFT, RIGHT
//   prepare_judge      in   FSM is waiting for a key; enables key capture
//   enable_counter     in   clear and restart the wait timer
//   change_instruction in   new instruction / new round (edge-detected)
//   decrease_life      in   round lost (edge-detected)
//   key_pressed        out  any synchronized key down, and not game over
//   answer             out  captured key satisfies the current instruction
//   wait_counter       out  wait timer expired (registered)
//   instr_dir[1:0]     out  instruction direction (key_n index encoding)
//   instr_not          out  instruction is "NOT instr_dir"
//   lives[1:0]         out  remaining lives
//   score[7:0]         out  correct rounds, saturating at 255
//   game_over          out  lives reached 0; sticky until reset
// -----------------------------------------------------------------------------
module not_judge_datapath
  import not_game_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int          CNT_W       = 26,
  parameter int unsigned LIVES_INIT  = LIVES_INIT_DEF,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  input  logic       prepare_judge,
  input  logic       enable_counter,
  input  logic       change_instruction,
  input  logic       decrease_life,
  output logic       key_pressed,
  output logic       answer,
  output logic       wait_counter,
  output logic [1:0] instr_dir,
  output logic       instr_not,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over
);

  // Key synchronizer. It resets to all-ones because the buttons are active-low.
  logic [3:0] ksync1_q, ksync2_q;
  logic [3:0] keys_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ksync1_q <= 4'hF;
      ksync2_q <= 4'hF;
    end else begin
      ksync1_q <= key_n;
      ksync2_q <= ksync1_q;
    end
  end

  assign keys_down = ~ksync2_q;

  // Strobe edge detection. The FSM may hold a strobe high for two cycles,
  // so every effect keys off the rising edge only.
  logic chg_prev_q, dl_prev_q;
  logic chg_rise, dl_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_prev_q <= 1'b0;
      dl_prev_q  <= 1'b0;
    end else begin
      chg_prev_q <= change_instruction;
      dl_prev_q  <= decrease_life;
    end
  end

  assign chg_rise = change_instruction & ~chg_prev_q;
  assign dl_rise  = decrease_life & ~dl_prev_q;

  // Game state registers
  logic [7:0] lfsr_q,      lfsr_d;
  logic       key_valid_q, key_valid_d;
  dir_t       key_idx_q,   key_idx_d;
  dir_t       instr_dir_q, instr_dir_d;
  logic       instr_not_q, instr_not_d;
  logic [7:0] score_q,     score_d;
  logic [1:0] lives_q,     lives_d;
  logic       game_over_q, game_over_d;
  logic       key_pressed_w;

  assign key_pressed_w = (|keys_down) & ~game_over_q;

  always_comb begin
    lfsr_d      = lfsr_next(lfsr_q);
    key_valid_d = key_valid_q;
    key_idx_d   = key_idx_q;
    instr_dir_d = instr_dir_q;
    instr_not_d = instr_not_q;
    score_d     = score_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;

    // The round-start clear takes priority over a capture in the same cycle.
    if (chg_rise) begin
      key_valid_d = 1'b0;
    end else if (prepare_judge && key_pressed_w && !key_valid_q) begin
      key_valid_d = 1'b1;
      key_idx_d   = lowest_key(keys_down);
    end

    if (chg_rise) begin
      instr_dir_d = lfsr_q[1:0];
      instr_not_d = lfsr_q[2];
      // A rise with enable_counter low is the start of the game, not a won round.
      if (enable_counter && !decrease_life && (score_q != 8'hFF)) begin
        score_d = score_q + 8'd1;
      end
    end

    if (dl_rise && (lives_q != 2'd0)) begin
      lives_d = lives_q - 2'd1;
    end

    // Registered one cycle behind lives reaching zero; never cleared.
    if (lives_q == 2'd0) begin
      game_over_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= LFSR_SEED;
      key_valid_q <= 1'b0;
      key_idx_q   <= DIR_UP;
      instr_dir_q <= DIR_UP;
      instr_not_q <= 1'b0;
      score_q     <= 8'd0;
      lives_q     <= 2'(LIVES_INIT);
      game_over_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      key_valid_q <= key_valid_d;
      key_idx_q   <= key_idx_d;
      instr_dir_q <= instr_dir_d;
      instr_not_q <= instr_not_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
    end
  end

  wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (enable_counter),
    .expired_o (wait_counter)
  );

  // The judgement is built only from registers. It therefore stays valid
  // after the player lets go of the key.
  assign answer = key_valid_q &
                  (instr_not_q ? (key_idx_q != instr_dir_q)
                               : (key_idx_q == instr_dir_q));

  assign key_pressed = key_pressed_w;
  assign instr_dir   = instr_dir_q;
  assign instr_not   = instr_not_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign game_over   = game_over_q;

endmodule
